// File: rtl/uart_report_formatter.sv
// rtl/uart_report_formatter.sv - snapshots N_CH BCD readings and streams one ASCII report line per channel
module uart_report_formatter #(
    parameter int N_CH   = 13,
    parameter int DIGITS = 4,
    parameter int PERIOD = 65_000_000,
    parameter int AUTO   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*4*DIGITS-1:0] ch_bcd,
    input  logic                     trig,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int W   = N_CH * 4 * DIGITS;
    localparam int LW  = 4 * DIGITS;
    localparam int LEN = DIGITS + 10;
    localparam int BW  = 5;
    localparam int CW  = $clog2(N_CH + 1);
    localparam int PW  = $clog2(PERIOD);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    snap;
    logic [BW-1:0]   byte_idx;
    logic [CW-1:0]   ch_idx;
    logic [3:0]      lbl_tens, lbl_units;
    logic [PW-1:0]   per_cnt;
    logic            auto_pend;
    logic            auto_hit, start, accept, last_byte, last_ch;
    logic [3:0]      cur_nib;
    logic [7:0]      tx_byte;

    function automatic logic [7:0] bcd_ascii(input logic [3:0] n);
        return (n <= 4'd9) ? {4'h3, n} : 8'h3F;
    endfunction

    assign auto_hit  = (AUTO != 0) && (per_cnt == PW'(PERIOD - 1));
    assign start     = (state == IDLE) && (trig || auto_pend || auto_hit);
    assign accept    = (state == SEND) && tx_ready;
    assign last_byte = (byte_idx == BW'(LEN - 1));
    assign last_ch   = (ch_idx == CW'(N_CH - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SEND;
            SEND:    if (accept && last_byte && last_ch) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            snap      <= '0;
            byte_idx  <= '0;
            ch_idx    <= '0;
            lbl_tens  <= 4'd0;
            lbl_units <= 4'd0;
            per_cnt   <= '0;
            auto_pend <= 1'b0;
        end else begin
            state <= state_nx;

            if (start || per_cnt == PW'(PERIOD - 1))
                per_cnt <= '0;
            else
                per_cnt <= per_cnt + 1'b1;

            // a periodic request landing while busy waits for the next IDLE cycle
            if (start)
                auto_pend <= 1'b0;
            else if (auto_hit)
                auto_pend <= 1'b1;

            if (start) begin
                snap      <= ch_bcd;
                byte_idx  <= '0;
                ch_idx    <= '0;
                lbl_tens  <= 4'd0;
                lbl_units <= 4'd1;
            end else if (accept) begin
                if (last_byte) begin
                    byte_idx <= '0;
                    ch_idx   <= ch_idx + 1'b1;
                    // the current channel always sits in the low bits of the snapshot
                    snap     <= snap >> LW;
                    if (lbl_units == 4'd9) begin
                        lbl_units <= 4'd0;
                        lbl_tens  <= lbl_tens + 4'd1;
                    end else begin
                        lbl_units <= lbl_units + 4'd1;
                    end
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        cur_nib = 4'd0;
        for (int j = 0; j < DIGITS; j++)
            if (byte_idx == BW'(6 + j)) cur_nib = snap[(DIGITS-1-j)*4 +: 4];
    end

    always_comb begin
        tx_byte = 8'h00;
        if (byte_idx == BW'(0))                tx_byte = 8'h56;
        else if (byte_idx == BW'(1))           tx_byte = {4'h3, lbl_tens};
        else if (byte_idx == BW'(2))           tx_byte = {4'h3, lbl_units};
        else if (byte_idx == BW'(3))           tx_byte = 8'h20;
        else if (byte_idx == BW'(4))           tx_byte = 8'h2D;
        else if (byte_idx == BW'(5))           tx_byte = 8'h20;
        else if (byte_idx < BW'(6 + DIGITS))   tx_byte = bcd_ascii(cur_nib);
        else if (byte_idx == BW'(6 + DIGITS))  tx_byte = 8'h20;
        else if (byte_idx == BW'(7 + DIGITS))  tx_byte = 8'h56;
        else if (byte_idx == BW'(8 + DIGITS))  tx_byte = 8'h0A;
        else if (byte_idx == BW'(9 + DIGITS))  tx_byte = 8'h0D;
    end

    assign tx_data    = (state == SEND) ? tx_byte : 8'h00;
    assign tx_valid   = (state == SEND);
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

endmodule
